// File: rtl/priority_encoder_pkg.sv
// Shared constants and helpers for the registered priority encoder.
package priority_encoder_pkg;

    localparam int DefaultEncodingSize = 3;

    // Width of the request vector for a given index width.
    function automatic int vecWidth(input int encodingSize);
        return 1 << encodingSize;
    endfunction

endpackage

// File: rtl/priority_encoder_if.sv
// Request/result bundle between a consumer and the priority encoder.
interface priority_encoder_if
    import priority_encoder_pkg::*;
#(
    parameter int EncodingSize = DefaultEncodingSize
);
    localparam int Width = vecWidth(EncodingSize);

    logic [0:Width-1]        in;
    logic                    pe_en;
    logic [EncodingSize-1:0] out;
    logic                    pe_found;
    logic                    pe_finish;

    modport master (
        output in,
        output pe_en,
        input  out,
        input  pe_found,
        input  pe_finish
    );

    modport slave (
        input  in,
        input  pe_en,
        output out,
        output pe_found,
        output pe_finish
    );
endinterface

// File: rtl/priority_encoder_pe_node.sv
// Tree cell: merges two (valid, index) pairs, the left (lower-index) side
// winning, and sets the index bit that this tree level contributes.
module pe_node
    import priority_encoder_pkg::*;
#(
    parameter int EncodingSize = DefaultEncodingSize,
    parameter int Level        = 0
) (
    input  logic                    i_leftValid,
    input  logic [EncodingSize-1:0] i_leftIdx,
    input  logic                    i_rightValid,
    input  logic [EncodingSize-1:0] i_rightIdx,
    output logic                    o_valid,
    output logic [EncodingSize-1:0] o_idx
);

    // Left child has priority; an empty subtree reports index 0.
    always_comb begin
        o_valid = i_leftValid | i_rightValid;
        o_idx   = '0;
        if (i_leftValid) begin
            o_idx = i_leftIdx;
        end else if (i_rightValid) begin
            o_idx        = i_rightIdx;
            o_idx[Level] = 1'b1;
        end
    end

endmodule

// File: rtl/priority_encoder.sv
// Registered priority encoder: returns the lowest asserted index of the
// request vector one clock after each pe_en strobe.
module priority_encoder
    import priority_encoder_pkg::*;
#(
    parameter int EncodingSize = DefaultEncodingSize
) (
    input  logic               clock,
    input  logic               reset_n,
    priority_encoder_if.slave  bus
);

    localparam int Width = vecWidth(EncodingSize);

    // Heap-ordered tree: node 1 is the root, nodes Width..2*Width-1 are the
    // request bits, and node n merges children 2n (left) and 2n+1 (right).
    logic                    w_valid [1:2*Width-1];
    logic [EncodingSize-1:0] w_idx   [1:2*Width-1];

    logic [EncodingSize-1:0] r_out;
    logic                    r_found;
    logic                    r_finish;

    genvar j, lvl, n;

    generate
        for (j = 0; j < Width; j++) begin : g_leaf
            assign w_valid[Width+j] = bus.in[j];
            assign w_idx[Width+j]   = '0;
        end

        for (lvl = 0; lvl < EncodingSize; lvl++) begin : g_level
            for (n = (Width >> (lvl + 1)); n < (Width >> lvl); n++) begin : g_node
                pe_node #(
                    .EncodingSize (EncodingSize),
                    .Level        (lvl)
                ) u_node (
                    .i_leftValid  (w_valid[2*n]),
                    .i_leftIdx    (w_idx[2*n]),
                    .i_rightValid (w_valid[2*n+1]),
                    .i_rightIdx   (w_idx[2*n+1]),
                    .o_valid      (w_valid[n]),
                    .o_idx        (w_idx[n])
                );
            end
        end
    endgenerate

    // Capture the tree result on a strobe; otherwise hold it and drop finish.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out    <= '0;
            r_found  <= 1'b0;
            r_finish <= 1'b0;
        end else if (bus.pe_en) begin
            r_out    <= w_idx[1];
            r_found  <= w_valid[1];
            r_finish <= 1'b1;
        end else begin
            r_finish <= 1'b0;
        end
    end

    assign bus.out       = r_out;
    assign bus.pe_found  = r_found;
    assign bus.pe_finish = r_finish;

endmodule

// File: tb/tb_priority_encoder.sv
// Self-checking bench for priority_encoder (EncodingSize = 3).
module tb_priority_encoder;

    typedef struct packed {
        logic [7:0] vin;
        logic [2:0] expOut;
        logic       expFound;
    } vec_t;

    logic clock;
    logic reset_n;
    int   checks;
    int   failures;
    vec_t vecs [10];

    priority_encoder_if #(.EncodingSize(3)) bus ();

    priority_encoder #(.EncodingSize(3)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive inputs on the falling edge, let one rising edge sample them,
    // then settle 1 time unit so outputs are read away from the edge.
    task automatic applyStimulus(input logic [7:0] vin, input logic en);
        @(negedge clock);
        bus.in    = vin;
        bus.pe_en = en;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] expOut,
                               input logic expFound, input logic expFinish);
        checks++;
        if (bus.out !== expOut) begin
            failures++;
            $display("[TB] FAIL %s out: got %0d expected %0d", name, bus.out, expOut);
        end
        checks++;
        if (bus.pe_found !== expFound) begin
            failures++;
            $display("[TB] FAIL %s pe_found: got %b expected %b", name, bus.pe_found, expFound);
        end
        checks++;
        if (bus.pe_finish !== expFinish) begin
            failures++;
            $display("[TB] FAIL %s pe_finish: got %b expected %b", name, bus.pe_finish, expFinish);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0] = '{8'b1001_0000, 3'd0, 1'b1};
        vecs[1] = '{8'b1000_1100, 3'd0, 1'b1};
        vecs[2] = '{8'b0100_0000, 3'd1, 1'b1};
        vecs[3] = '{8'b0110_0000, 3'd1, 1'b1};
        vecs[4] = '{8'b0001_0000, 3'd3, 1'b1};
        vecs[5] = '{8'b0000_0001, 3'd7, 1'b1};
        vecs[6] = '{8'b0000_0000, 3'd0, 1'b0};
        vecs[7] = '{8'b0000_0100, 3'd5, 1'b1};
        vecs[8] = '{8'b1111_1111, 3'd0, 1'b1};
        vecs[9] = '{8'b0000_0011, 3'd6, 1'b1};

        // Power-on reset values.
        reset_n   = 1'b0;
        bus.in    = 8'h00;
        bus.pe_en = 1'b0;
        #1;
        checkOutput("reset_initial", 3'd0, 1'b0, 1'b0);

        @(negedge clock);
        reset_n = 1'b1;

        // No strobe after release: outputs stay at reset values.
        applyStimulus(8'b1000_0000, 1'b0);
        checkOutput("post_reset_no_en", 3'd0, 1'b0, 1'b0);
        applyStimulus(8'b0000_0001, 1'b0);
        checkOutput("post_reset_no_en2", 3'd0, 1'b0, 1'b0);

        // Table: one strobe per vector, then a quiet edge that must hold.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].vin, 1'b1);
            checkOutput($sformatf("vec%0d_encode", i), vecs[i].expOut, vecs[i].expFound, 1'b1);
            applyStimulus(vecs[i].vin, 1'b0);
            checkOutput($sformatf("vec%0d_hold", i), vecs[i].expOut, vecs[i].expFound, 1'b0);
        end

        // Input changes without a strobe are ignored, including X.
        applyStimulus(8'b0001_0000, 1'b1);
        checkOutput("hold_setup", 3'd3, 1'b1, 1'b1);
        applyStimulus(8'b1000_0000, 1'b0);
        checkOutput("hold_in_change", 3'd3, 1'b1, 1'b0);
        applyStimulus(8'bxxxx_xxxx, 1'b0);
        checkOutput("hold_in_x", 3'd3, 1'b1, 1'b0);

        // Back-to-back strobes: a fresh result every cycle.
        applyStimulus(8'b1000_0000, 1'b1);
        checkOutput("b2b_0", 3'd0, 1'b1, 1'b1);
        applyStimulus(8'b0010_0000, 1'b1);
        checkOutput("b2b_1", 3'd2, 1'b1, 1'b1);
        applyStimulus(8'b0000_0010, 1'b1);
        checkOutput("b2b_2", 3'd6, 1'b1, 1'b1);
        applyStimulus(8'b0000_0000, 1'b0);
        checkOutput("b2b_end", 3'd6, 1'b1, 1'b0);

        // Reset mid-run while pe_finish is high clears without a clock edge.
        applyStimulus(8'b0000_0100, 1'b1);
        checkOutput("midreset_setup", 3'd5, 1'b1, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_async", 3'd0, 1'b0, 1'b0);
        @(negedge clock);
        bus.pe_en = 1'b0;
        reset_n   = 1'b1;
        applyStimulus(8'b1000_0000, 1'b0);
        checkOutput("midreset_release", 3'd0, 1'b0, 1'b0);
        applyStimulus(8'b0100_0000, 1'b1);
        checkOutput("midreset_reencode", 3'd1, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
